// File: rtl/bus_timer_if.sv
// rtl/bus_timer_if.sv - CPU-side register bus bundle for bus_timer
interface bus_timer_if;
    logic        cpu_read_mem;
    logic        cpu_write_mem;
    logic [31:0] addr;
    logic [31:0] idata_from_cpu;
    logic [31:0] odata_to_cpu;
    logic        error;
    logic        irq;

    modport master (
        output cpu_read_mem, cpu_write_mem, addr, idata_from_cpu,
        input  odata_to_cpu, error, irq
    );

    modport slave (
        input  cpu_read_mem, cpu_write_mem, addr, idata_from_cpu,
        output odata_to_cpu, error, irq
    );
endinterface

// File: rtl/bus_timer.sv
// rtl/bus_timer.sv - memory-mapped down-counting timer; optional prescaler under BUS_TIMER_PRESCALER_EN
module bus_timer #(
    parameter logic [31:0] BASE_ADDR = 32'hF000_0000
) (
    input  logic        clk,
    input  logic        rst,
    bus_timer_if.slave  bus
);
    localparam logic [2:0] R_CTRL     = 3'd0;
    localparam logic [2:0] R_LOAD     = 3'd1;
    localparam logic [2:0] R_COUNT    = 3'd2;
    localparam logic [2:0] R_STATUS   = 3'd3;
    localparam logic [2:0] R_PRESCALE = 3'd4;

    logic        en, auto_reload, irq_en;
    logic [31:0] load_q, count_q;
    logic        expired;
    logic [31:0] rdata;
    logic        legal_idx, fault, access, rd_ok, wr_ok;
    logic        ctrl_wr, load_wr, status_wr, en_rise;
    logic        tick, expire;
    logic [2:0]  idx;
    logic [31:0] wdata;

    assign idx   = bus.addr[4:2];
    assign wdata = bus.idata_from_cpu;

    // Which word offsets exist in this build; the rest of the window faults
    always_comb begin
        legal_idx = 1'b0;
        case (idx)
            R_CTRL, R_LOAD, R_COUNT, R_STATUS: legal_idx = 1'b1;
`ifdef BUS_TIMER_PRESCALER_EN
            R_PRESCALE: legal_idx = 1'b1;
`else
            R_PRESCALE: legal_idx = 1'b0;
`endif
            default: legal_idx = 1'b0;
        endcase
    end

    assign access = (bus.addr[31:5] == BASE_ADDR[31:5]) &&
                    (bus.cpu_read_mem || bus.cpu_write_mem);
    assign fault  = access && ((bus.addr[1:0] != 2'b00) ||
                               (bus.cpu_read_mem && bus.cpu_write_mem) ||
                               !legal_idx ||
                               (bus.cpu_write_mem && idx == R_COUNT));
    assign rd_ok  = access && !fault && bus.cpu_read_mem;
    assign wr_ok  = access && !fault && bus.cpu_write_mem;

    assign ctrl_wr   = wr_ok && idx == R_CTRL;
    assign load_wr   = wr_ok && idx == R_LOAD;
    assign status_wr = wr_ok && idx == R_STATUS;
    assign en_rise   = ctrl_wr && wdata[0] && !en;

`ifdef BUS_TIMER_PRESCALER_EN
    logic [7:0] prescale_q, psc_cnt;
    logic       prescale_wr;

    assign prescale_wr = wr_ok && idx == R_PRESCALE;
    assign tick        = en && (psc_cnt == prescale_q);

    // Prescale divider register and its free-running cycle counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prescale_q <= 8'd0;
            psc_cnt    <= 8'd0;
        end else begin
            if (prescale_wr)
                prescale_q <= wdata[7:0];
            if (en_rise || prescale_wr)
                psc_cnt <= 8'd0;
            else if (en)
                psc_cnt <= tick ? 8'd0 : psc_cnt + 8'd1;
        end
    end
`else
    assign tick = en;
`endif

    assign expire = tick && (count_q == 32'd0);

    // Read mux; COUNT returns the pre-decrement value
    always_comb begin
        rdata = 32'd0;
        case (idx)
            R_CTRL:   rdata = {29'd0, irq_en, auto_reload, en};
            R_LOAD:   rdata = load_q;
            R_COUNT:  rdata = count_q;
            R_STATUS: rdata = {31'd0, expired};
`ifdef BUS_TIMER_PRESCALER_EN
            R_PRESCALE: rdata = {24'd0, prescale_q};
`endif
            default:  rdata = 32'd0;
        endcase
    end

    // Control bits; a CTRL write overrides the one-shot auto-stop
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en          <= 1'b0;
            auto_reload <= 1'b0;
            irq_en      <= 1'b0;
        end else if (ctrl_wr) begin
            en          <= wdata[0];
            auto_reload <= wdata[1];
            irq_en      <= wdata[2];
        end else if (expire && !auto_reload) begin
            en <= 1'b0;
        end
    end

    // Reload value only; never touches the running count
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            load_q <= 32'd0;
        else if (load_wr)
            load_q <= wdata;
    end

    // Counter: start-load, stop-hold, expiry reload/hold, else decrement
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count_q <= 32'd0;
        else if (en_rise)
            count_q <= load_q;
        else if (ctrl_wr && !wdata[0])
            count_q <= count_q;
        else if (expire)
            count_q <= auto_reload ? load_q : count_q;
        else if (tick)
            count_q <= count_q - 32'd1;
    end

    // Sticky expiry flag; a same-cycle expiry beats the W1C clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            expired <= 1'b0;
        else if (expire)
            expired <= 1'b1;
        else if (status_wr && wdata[0])
            expired <= 1'b0;
    end

    // One-cycle registered response; zero for misses, writes and idle cycles
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.odata_to_cpu <= 32'd0;
            bus.error        <= 1'b0;
        end else begin
            bus.odata_to_cpu <= rd_ok ? rdata : 32'd0;
            bus.error        <= fault;
        end
    end

    assign bus.irq = expired && irq_en;
endmodule

// File: tb/tb_bus_timer.sv
// tb/tb_bus_timer.sv - self-checking bench for bus_timer with a behavioural register model
module tb_bus_timer;
    localparam logic [31:0] BASE = 32'hF000_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    bus_timer_if bus();

    bus_timer #(.BASE_ADDR(BASE)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    // behavioural model state
    bit          m_en, m_auto, m_ie, m_exp;
    logic [31:0] m_load, m_count;
    logic [7:0]  m_pre, m_psc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_en = 0; m_auto = 0; m_ie = 0; m_exp = 0;
        m_load = 0; m_count = 0; m_pre = 0; m_psc = 0;
    endtask

    // One clock edge of the timer, described by its register-map rules
    task automatic model_step(input bit rd, input bit wr, input logic [31:0] a,
                              input logic [31:0] d, output logic [31:0] ed, output bit ee);
        bit          hit, bad, do_wr, tick, expire;
        logic [4:0]  off;
        int          top_off;
        bit          n_en, n_exp;
        logic [31:0] n_count;
        logic [7:0]  n_psc;
`ifdef BUS_TIMER_PRESCALER_EN
        top_off = 16;
`else
        top_off = 12;
`endif
        hit = (a[31:5] == BASE[31:5]);
        off = a[4:0];
        ed = 0; ee = 0; do_wr = 0;
        if (hit && (rd || wr)) begin
            bad = (off % 4 != 0) || (rd && wr) || (int'(off) > top_off) || (wr && off == 8);
            if (bad) ee = 1;
            else if (wr) do_wr = 1;
            else case (off)
                0:  ed = {29'd0, m_ie, m_auto, m_en};
                4:  ed = m_load;
                8:  ed = m_count;
                12: ed = {31'd0, m_exp};
                default: ed = {24'd0, m_pre};
            endcase
        end
`ifdef BUS_TIMER_PRESCALER_EN
        tick = m_en && (m_psc == m_pre);
`else
        tick = m_en;
`endif
        expire = tick && m_count == 0;
        n_en = m_en; n_exp = m_exp; n_count = m_count; n_psc = m_psc;
        if (m_en) n_psc = tick ? 8'd0 : m_psc + 8'd1;
        if (expire) begin
            n_exp = 1;
            if (m_auto) n_count = m_load; else n_en = 0;
        end else if (tick) n_count = m_count - 1;
        if (do_wr) begin
            if (off == 0) begin
                n_en = d[0];
                if (!d[0]) n_count = m_count;
                else if (!m_en) begin n_count = m_load; n_psc = 0; end
                m_auto = d[1]; m_ie = d[2];
            end
            if (off == 4) m_load = d;
            if (off == 12 && d[0] && !expire) n_exp = 0;
            if (off == 16) begin m_pre = d[7:0]; n_psc = 0; end
        end
        m_en = n_en; m_exp = n_exp; m_count = n_count; m_psc = n_psc;
    endtask

    task automatic cyc(input string tag, input bit rd, input bit wr,
                       input logic [31:0] a, input logic [31:0] d);
        logic [31:0] ed;
        bit          ee;
        @(negedge clk);
        bus.cpu_read_mem   = rd;
        bus.cpu_write_mem  = wr;
        bus.addr           = a;
        bus.idata_from_cpu = d;
        model_step(rd, wr, a, d, ed, ee);
        @(posedge clk);
        #1;
        check({tag, "_data"}, bus.odata_to_cpu, ed);
        check({tag, "_err"},  {31'd0, bus.error}, {31'd0, ee});
        check({tag, "_irq"},  {31'd0, bus.irq}, {31'd0, m_exp & m_ie});
    endtask

    initial begin
        logic [31:0] a, d;
        bit          rd, wr;
        int          r;
        bus.cpu_read_mem = 0; bus.cpu_write_mem = 0; bus.addr = 0; bus.idata_from_cpu = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_data", bus.odata_to_cpu, 0);
        check("rst_err", {31'd0, bus.error}, 0);
        check("rst_irq", {31'd0, bus.irq}, 0);
        @(negedge clk) rst = 0;

        // one-shot count 3,2,1,0 then expire with irq
        cyc("ld3", 0, 1, BASE + 4, 3);
        cyc("ctrl5", 0, 1, BASE + 0, 5);
        for (int k = 3; k >= 0; k--) begin
            cyc("cnt", 1, 0, BASE + 8, 0);
            check("oneshot_count", bus.odata_to_cpu, k);
        end
        check("oneshot_irq", {31'd0, bus.irq}, 1);
        cyc("ctrl_rd", 1, 0, BASE + 0, 0);
        check("oneshot_ctrl", bus.odata_to_cpu, 4);
        cyc("cnt_hold", 1, 0, BASE + 8, 0);
        check("oneshot_hold", bus.odata_to_cpu, 0);
        cyc("clr", 0, 1, BASE + 12, 1);
        check("clr_irq", {31'd0, bus.irq}, 0);

        // auto-reload every 2 ticks; set beats clear
        cyc("ld1", 0, 1, BASE + 4, 1);
        cyc("ctrl3", 0, 1, BASE + 0, 3);
        cyc("idle", 0, 0, 0, 0);
        cyc("idle", 0, 0, 0, 0);
        cyc("clr_a", 0, 1, BASE + 12, 1);
        cyc("clr_b", 0, 1, BASE + 12, 1);
        cyc("st_rd", 1, 0, BASE + 12, 0);
        check("set_beats_clear", bus.odata_to_cpu, 1);
        cyc("stop", 0, 1, BASE + 0, 0);

        // access faults leave registers alone
        cyc("ld55", 0, 1, BASE + 4, 32'h55);
        cyc("mis_rd", 1, 0, BASE + 2, 0);
        check("misalign_err", {31'd0, bus.error}, 1);
        cyc("cnt_wr", 0, 1, BASE + 8, 7);
        check("count_wr_err", {31'd0, bus.error}, 1);
        cyc("both", 1, 1, BASE + 4, 32'h99);
        check("both_err", {31'd0, bus.error}, 1);
        cyc("idle", 0, 0, 0, 0);
        check("err_one_cycle", {31'd0, bus.error}, 0);
        cyc("ld_rd", 1, 0, BASE + 4, 0);
        check("load_kept", bus.odata_to_cpu, 32'h55);
        cyc("res14", 1, 0, BASE + 32'h14, 0);
        check("reserved_err", {31'd0, bus.error}, 1);

        // miss and plain readback
        cyc("miss", 1, 0, 32'h0000_1000, 0);
        check("miss_data", bus.odata_to_cpu, 0);
        check("miss_err", {31'd0, bus.error}, 0);
        cyc("ldbeef", 0, 1, BASE + 4, 32'hDEAD_BEEF);
        cyc("ld_rd", 1, 0, BASE + 4, 0);
        check("load_beef", bus.odata_to_cpu, 32'hDEAD_BEEF);
        cyc("idle", 0, 0, 0, 0);
        check("data_one_cycle", bus.odata_to_cpu, 0);

`ifdef BUS_TIMER_PRESCALER_EN
        cyc("pre3", 0, 1, BASE + 16, 3);
        cyc("ld2", 0, 1, BASE + 4, 2);
        cyc("ctrl1", 0, 1, BASE + 0, 1);
        for (int k = 1; k <= 12; k++) begin
            cyc("pcnt", 1, 0, BASE + 8, 0);
            check("prescaled_count", bus.odata_to_cpu, (k <= 4) ? 2 : (k <= 8) ? 1 : 0);
        end
        cyc("pre0", 0, 1, BASE + 16, 0);
`else
        cyc("pre_rd", 1, 0, BASE + 16, 0);
        check("prescale_reserved", {31'd0, bus.error}, 1);
`endif

        // randomized traffic against the model
        for (int i = 0; i < 300; i++) begin
            r  = $urandom_range(0, 9);
            rd = (r < 4) || (r == 9);
            wr = (r >= 4 && r < 8) || (r == 9);
            a  = BASE + 4 * $urandom_range(0, 7);
            if ($urandom_range(0, 9) == 0) a = a + $urandom_range(1, 3);
            if ($urandom_range(0, 11) == 0) a = $urandom;
            case (a[4:0])
                0:  d = $urandom_range(0, 7);
                4:  d = $urandom_range(0, 5);
                16: d = $urandom_range(0, 2);
                default: d = $urandom;
            endcase
            cyc("rnd", rd, wr, a, d);
        end

        // asynchronous reset mid-count
        cyc("ld0", 0, 1, BASE + 4, 0);
        cyc("ctrl7", 0, 1, BASE + 0, 7);
        cyc("idle", 0, 0, 0, 0);
        cyc("ctrl_rd", 1, 0, BASE + 0, 0);
        check("pre_rst_ctrl", bus.odata_to_cpu, 7);
        check("pre_rst_irq", {31'd0, bus.irq}, 1);
        #2 rst = 1;
        #1;
        check("async_rst_data", bus.odata_to_cpu, 0);
        check("async_rst_err", {31'd0, bus.error}, 0);
        check("async_rst_irq", {31'd0, bus.irq}, 0);
        bus.cpu_read_mem = 0;
        model_reset();
        @(posedge clk);
        @(negedge clk) rst = 0;
        cyc("post_rst", 1, 0, BASE + 0, 0);
        check("post_rst_ctrl", bus.odata_to_cpu, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
